ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Parametrised next-generation control unit for the pipelined TSC CPU.
- Decodes opcode/funcode in ID into the control bundle.
- Carries that bundle through ID/EX, EX/MEM and MEM/WB registers, with stall, flush and global-hold handling.
- Tracks halt and counts retired instructions, so the datapath no longer builds its own control pipeline registers.

Parameters:
- OPCODE_BITS, 4, opcode width.
- FUNCODE_BITS, 6, function-code width.
- NUM_INST_W, 16, retired-instruction counter width.
- HLT_FUNC, 29, funcode of HLT. WWD_FUNC, 28. JPR_FUNC, 25. JRL_FUNC, 26.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  OPCODE_BITS  ID opcode
- id_funcode  in  FUNCODE_BITS  ID funcode
- is_taken  in  1  branch condition true (from ID comparator)
- stall  in  1  load-use hazard: ID instruction is not issued; bubble into EX
- flush  in  1  ID instruction is wrong-path; bubble into EX
- hold  in  1  freeze the entire control pipeline (memory wait)
- id_pcsrc  out  2  00 inc, 01 offset, 10 concat, 11 register
- id_regdest  out  1  1 = rd (R-type), 0 = rt
- ex_opcode  out  OPCODE_BITS  EX-stage ALU opcode
- ex_funcode  out  FUNCODE_BITS  EX-stage ALU funcode
- ex_alusrc  out  1  EX-stage ALU source select
- mem_read  out  1  MEM-stage read enable
- mem_write  out  1  MEM-stage write enable
- wb_isinst  out  1  WB-stage control bit
- wb_ishalt  out  1  WB-stage control bit
- wb_iswwd  out  1  WB-stage control bit
- wb_regwrite  out  1  WB-stage control bit
- wb_memtoreg  out  1  WB-stage control bit
- wb_reg2save  out  1  WB-stage control bit
- halted  out  1  sticky; high once HLT has retired
- num_inst  out  NUM_INST_W  retired-instruction count

Behaviour:
- Decode rules (op = id_opcode, fn = id_funcode):
  - regwrite = op in 4..7 or 10..15, except op 15 with fn in {JPR, WWD, HLT}.
  - memtoreg = memread = (op == 7). memwrite = (op == 8).
  - alusrc = op in 4..8.
  - reg2save = (op == 10) or (op == 15 and fn == JRL).
  - ishalt = (op == 15 and fn == HLT). iswwd = (op == 15 and fn == WWD). isinst = 1.
  - regdest = (op == 15).
- id_pcsrc (combinational):
  - Forced to 00 when any of: !id_valid, stall, flush, halt_pending.
  - Otherwise 01 if op <= 3 and is_taken; 10 if op in 9..10; 11 if op 15 and fn in {JPR, JRL}; else 00.
- id_regdest is combinational and never gated.
- Issue: issue = id_valid & !stall & !flush & !halt_pending.
- Pipeline registers:
  - When hold=1, every register keeps its value (including halt_pending, halted, num_inst).
  - Otherwise, on each edge, ID/EX loads the decoded bundle if issue, else all-zero (bubble, isinst=0); EX/MEM loads ID/EX; MEM/WB loads EX/MEM.
- Latency: an instruction issued at edge N drives ex_* after N, mem_* after N+1, wb_* after N+2, with no hold in between.
- Bubbles: all outputs of a bubble are 0, including ex_opcode and ex_funcode.
- halt_pending:
  - Set at an edge where issue=1, hold=0 and the decoded instruction is HLT.
  - Cleared only by reset.
  - While set, nothing further issues and id_pcsrc is 00.
- halted: set at an edge where wb_ishalt=1 and hold=0; sticky until reset.
- num_inst:
  - Increments by 1 at an edge where wb_isinst=1, hold=0 and halted=0.
  - The HLT itself counts.
  - Wraps modulo 2^NUM_INST_W.
- Simultaneous inputs:
  - hold beats stall and flush.
  - stall and flush together produce a single bubble.
  - is_taken is ignored for non-branch opcodes.
- Reset (asserted at any time, including mid-pipeline): asynchronously zeroes all stage registers, halt_pending, halted and num_inst. All registered outputs read 0 immediately.
- After reset release, the first issue happens at the first edge with issue=1.

Test Plan:
- Reset mid-run with a LWD in MEM: pull reset_n low between edges → mem_read, wb_* and num_inst read 0 immediately, with no clock edge; after release, ADD (op 15, fn 0) retires 3 edges after issue and num_inst = 1.
- LWD (op 7) issued, then stall=1 for one cycle, then ADI (op 4):
  - ex_alusrc=1 and mem_read=1 on successive cycles for LWD.
  - The stalled cycle shows a bubble in EX with wb_isinst=0 two cycles later.
  - num_inst advances by exactly 2.
- BEQ (op 0) with is_taken=1:
  - id_pcsrc=01; with is_taken=0, id_pcsrc=00.
  - JMP (op 9) → 10. JRL (op 15, fn 26) → 11, and wb_reg2save=1 three cycles later.
  - Same JRL with flush=1 → id_pcsrc=00 and a bubble issues.
- hold=1 for 3 cycles while SWD (op 8) is in MEM: mem_write stays 1 for all 3 cycles, then 1 more after hold drops; num_inst frozen throughout.
- HLT (op 15, fn 29) followed by valid ADDs:
  - The ADDs never issue.
  - halted rises after the edge where wb_ishalt=1.
  - num_inst includes the HLT and stops afterwards.
- NUM_INST_W=4: retire 17 instructions → num_inst = 1 (wrap).

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus between the datapath (master) and ctrl_pipe (slave).
// Carries ID inputs, hazard controls and per-stage control outputs.
interface ctrl_pipe_if #(
  parameter int OPCODE_BITS  = 4,
  parameter int FUNCODE_BITS = 6,
  parameter int NUM_INST_W   = 16
);
  logic                    id_valid;
  logic [OPCODE_BITS-1:0]  id_opcode;
  logic [FUNCODE_BITS-1:0] id_funcode;
  logic                    is_taken;
  logic                    stall;
  logic                    flush;
  logic                    hold;
  logic [1:0]              id_pcsrc;
  logic                    id_regdest;
  logic [OPCODE_BITS-1:0]  ex_opcode;
  logic [FUNCODE_BITS-1:0] ex_funcode;
  logic                    ex_alusrc;
  logic                    mem_read;
  logic                    mem_write;
  logic                    wb_isinst;
  logic                    wb_ishalt;
  logic                    wb_iswwd;
  logic                    wb_regwrite;
  logic                    wb_memtoreg;
  logic                    wb_reg2save;
  logic                    halted;
  logic [NUM_INST_W-1:0]   num_inst;

  modport master (
    output id_valid, id_opcode, id_funcode,
    output is_taken, stall, flush, hold,
    input  id_pcsrc, id_regdest,
    input  ex_opcode, ex_funcode, ex_alusrc,
    input  mem_read, mem_write,
    input  wb_isinst, wb_ishalt, wb_iswwd,
    input  wb_regwrite, wb_memtoreg, wb_reg2save,
    input  halted, num_inst
  );

  modport slave (
    input  id_valid, id_opcode, id_funcode,
    input  is_taken, stall, flush, hold,
    output id_pcsrc, id_regdest,
    output ex_opcode, ex_funcode, ex_alusrc,
    output mem_read, mem_write,
    output wb_isinst, wb_ishalt, wb_iswwd,
    output wb_regwrite, wb_memtoreg, wb_reg2save,
    output halted, num_inst
  );
endinterface

// File: rtl/ctrl_pipe.sv
// TSC pipelined control unit: ID decode, ID/EX..MEM/WB control
// registers, halt tracking and retired-instruction counter.
module ctrl_pipe #(
  parameter int OPCODE_BITS  = 4,
  parameter int FUNCODE_BITS = 6,
  parameter int NUM_INST_W   = 16,
  parameter int HLT_FUNC     = 29,
  parameter int WWD_FUNC     = 28,
  parameter int JPR_FUNC     = 25,
  parameter int JRL_FUNC     = 26
) (
  input logic        clk,
  input logic        reset_n,
  ctrl_pipe_if.slave bus
);
  localparam int OW = OPCODE_BITS;
  localparam int FW = FUNCODE_BITS;

  localparam logic [OW-1:0] OP3  = OW'(3);
  localparam logic [OW-1:0] OP4  = OW'(4);
  localparam logic [OW-1:0] OP7  = OW'(7);
  localparam logic [OW-1:0] OP8  = OW'(8);
  localparam logic [OW-1:0] OP9  = OW'(9);
  localparam logic [OW-1:0] OP10 = OW'(10);
  localparam logic [OW-1:0] OP15 = OW'(15);
  localparam logic [OW-1:0] OPHI = ~OW'(15);

  localparam logic [FW-1:0] FN_HLT = FW'(HLT_FUNC);
  localparam logic [FW-1:0] FN_WWD = FW'(WWD_FUNC);
  localparam logic [FW-1:0] FN_JPR = FW'(JPR_FUNC);
  localparam logic [FW-1:0] FN_JRL = FW'(JRL_FUNC);

  typedef struct packed {
    logic isinst;
    logic ishalt;
    logic iswwd;
    logic regwrite;
    logic memtoreg;
    logic reg2save;
  } wb_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    wb_t  wb;
  } mem_t;

  typedef struct packed {
    logic [OW-1:0] opcode;
    logic [FW-1:0] funcode;
    logic          alusrc;
    mem_t          m;
  } ex_t;

  logic [OW-1:0] w_op;
  logic [FW-1:0] w_fn;
  logic          w_r15;
  logic          w_fhlt;
  logic          w_fwwd;
  logic          w_fjpr;
  logic          w_fjrl;
  logic          w_lo16;
  logic          w_issue;
  logic          w_brn;
  logic          w_jmp;
  logic          w_jr;
  logic [1:0]    w_pcsrc;
  ex_t           w_dec;

  ex_t                   r_ex;
  mem_t                  r_mem;
  wb_t                   r_wb;
  logic                  r_hpend;
  logic                  r_halted;
  logic [NUM_INST_W-1:0] r_num;

  assign w_op   = bus.id_opcode;
  assign w_fn   = bus.id_funcode;
  assign w_r15  = (w_op == OP15);
  assign w_fhlt = (w_fn == FN_HLT);
  assign w_fwwd = (w_fn == FN_WWD);
  assign w_fjpr = (w_fn == FN_JPR);
  assign w_fjrl = (w_fn == FN_JRL);
  assign w_lo16 = ((w_op & OPHI) == '0);

  always_comb begin
    w_dec                = '0;
    w_dec.opcode         = w_op;
    w_dec.funcode        = w_fn;
    w_dec.alusrc         = (w_op >= OP4) && (w_op <= OP8);
    w_dec.m.memread      = (w_op == OP7);
    w_dec.m.memwrite     = (w_op == OP8);
    w_dec.m.wb.isinst    = 1'b1;
    w_dec.m.wb.ishalt    = w_r15 && w_fhlt;
    w_dec.m.wb.iswwd     = w_r15 && w_fwwd;
    w_dec.m.wb.memtoreg  = (w_op == OP7);
    w_dec.m.wb.reg2save  = (w_op == OP10) || (w_r15 && w_fjrl);
    w_dec.m.wb.regwrite  =
      ((w_op >= OP4) && (w_op <= OP7)) ||
      ((w_op >= OP10) && w_lo16 &&
       !(w_r15 && (w_fjpr || w_fwwd || w_fhlt)));
  end

  assign w_issue = bus.id_valid && !bus.stall &&
                   !bus.flush && !r_hpend;

  assign w_brn = (w_op <= OP3) && bus.is_taken;
  assign w_jmp = (w_op == OP9) || (w_op == OP10);
  assign w_jr  = w_r15 && (w_fjpr || w_fjrl);

  always_comb begin
    w_pcsrc = 2'b00;
    if (w_issue) begin
      unique case (1'b1)
        w_brn:   w_pcsrc = 2'b01;
        w_jmp:   w_pcsrc = 2'b10;
        w_jr:    w_pcsrc = 2'b11;
        default: w_pcsrc = 2'b00;
      endcase
    end
  end

  // hold freezes every stage plus halt/counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_hpend  <= 1'b0;
      r_halted <= 1'b0;
      r_num    <= '0;
    end else if (!bus.hold) begin
      r_ex  <= w_issue ? w_dec : '0;
      r_mem <= r_ex.m;
      r_wb  <= r_mem.wb;
      if (w_issue && w_dec.m.wb.ishalt)
        r_hpend <= 1'b1;
      if (r_wb.ishalt)
        r_halted <= 1'b1;
      if (r_wb.isinst && !r_halted)
        r_num <= r_num + 1'b1;
    end
  end

  assign bus.id_pcsrc    = w_pcsrc;
  assign bus.id_regdest  = w_r15;
  assign bus.ex_opcode   = r_ex.opcode;
  assign bus.ex_funcode  = r_ex.funcode;
  assign bus.ex_alusrc   = r_ex.alusrc;
  assign bus.mem_read    = r_mem.memread;
  assign bus.mem_write   = r_mem.memwrite;
  assign bus.wb_isinst   = r_wb.isinst;
  assign bus.wb_ishalt   = r_wb.ishalt;
  assign bus.wb_iswwd    = r_wb.iswwd;
  assign bus.wb_regwrite = r_wb.regwrite;
  assign bus.wb_memtoreg = r_wb.memtoreg;
  assign bus.wb_reg2save = r_wb.reg2save;
  assign bus.halted      = r_halted;
  assign bus.num_inst    = r_num;
endmodule
